spi_cmd_decoder: RTL and testbench

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

---
 rtl/spi_cmd_decoder.sv | 153 +++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// Purpose : decodes command/operand bytes received by an SPI slave into counter
//           register updates, a readback byte and a sticky error flag.
// Latency : byte_valid rises SYNC_STAGES+1 clk edges after ce0 is first sampled
//           high; command effects land one edge after byte_valid.
// Backpressure: none; every byte is consumed in the cycle it is flagged.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   ce0            SPI chip enable (async to clk); rising edge closes a byte
//   data_incoming  byte from the SPI slave, stable around the ce0 rising edge
//   data_outgoing  byte the SPI slave shifts out on the next transfer
//   count_value    counter register for the downstream counter stage
//   load_pulse     one-cycle strobe: count_value was just loaded by an operand
//   byte_valid     one-cycle strobe: a new byte was captured
//   busy           high while an operand byte is expected
//   err            sticky illegal-command flag, cleared by reset or CLEAR
module spi_cmd_decoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce0,
  input  logic [7:0] data_incoming,
  output logic [7:0] data_outgoing,
  output logic [7:0] count_value,
  output logic       load_pulse,
  output logic       byte_valid,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_INC   = 8'h03;
  localparam logic [7:0] CMD_CLEAR = 8'h04;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_OPERAND = 1'b1
  } state_t;

  // ------------------------------------------------------------------
  // ce0 synchronizer and rising-edge detector.
  // All flops (including the edge-history flop) reset to 1 so a ce0 that
  // is simply held high across reset never looks like a rising edge.
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   ce0_s;
  logic                   ce0_rise;

  assign ce0_s    = sync_q[SYNC_STAGES-1];
  assign ce0_rise = ce0_s & ~sync_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '1;
      sync_prev_q <= 1'b1;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ce0};
      sync_prev_q <= ce0_s;
    end
  end

  // ------------------------------------------------------------------
  // Byte capture. data_incoming is stable from the ce0 rising edge until
  // the next falling edge, and the synchronized edge arrives well inside
  // that window, so sampling it here needs no further synchronization.
  // ------------------------------------------------------------------
  logic [7:0] byte_q;
  logic       byte_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= ce0_rise;
      if (ce0_rise) begin
        byte_q <= data_incoming;
      end
    end
  end

  // ------------------------------------------------------------------
  // Command FSM. Decodes byte_q during the byte_valid cycle, so every
  // effect is registered on the edge that ends that cycle. load_pulse is
  // raised on the same edge that loads count_value, so the two coincide.
  // ------------------------------------------------------------------
  state_t     state_q;
  logic [7:0] count_q;
  logic [7:0] dout_q;
  logic       err_q;
  logic       load_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= 8'h00;
      dout_q  <= 8'h00;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (byte_valid_q) begin
        case (state_q)
          ST_IDLE: begin
            case (byte_q)
              CMD_NOP: begin
                // no effect
              end
              CMD_WRITE: begin
                state_q <= ST_OPERAND;
              end
              CMD_READ: begin
                dout_q <= count_q;
              end
              CMD_INC: begin
                count_q <= count_q + 8'd1;
              end
              CMD_CLEAR: begin
                count_q <= 8'h00;
                err_q   <= 1'b0;
              end
              default: begin
                err_q <= 1'b1;
              end
            endcase
          end
          ST_OPERAND: begin
            // Every value is data here, including ones that look like commands.
            count_q <= byte_q;
            load_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign data_outgoing = dout_q;
  assign count_value   = count_q;
  assign load_pulse    = load_q;
  assign byte_valid    = byte_valid_q;
  assign busy          = (state_q == ST_OPERAND);
  assign err           = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Purpose : directed self-checking bench for spi_cmd_decoder (SYNC_STAGES=2).
// Latency : checks the SYNC_STAGES+1 edge byte latency and one-edge command effect.
// Backpressure: n/a; stimulus drives ce0 transfers at a fixed slow cadence.
module tb_spi_cmd_decoder;

  logic       clk;
  logic       reset;
  logic       ce0;
  logic [7:0] data_incoming;
  logic [7:0] data_outgoing;
  logic [7:0] count_value;
  logic       load_pulse;
  logic       byte_valid;
  logic       busy;
  logic       err;

  int checks;
  int errors;
  int bv_count;
  int lp_count;
  int sent;
  int lp_before;
  logic [7:0] last_load_val;

  spi_cmd_decoder #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .ce0           (ce0),
    .data_incoming (data_incoming),
    .data_outgoing (data_outgoing),
    .count_value   (count_value),
    .load_pulse    (load_pulse),
    .byte_valid    (byte_valid),
    .busy          (busy),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (byte_valid === 1'b1) bv_count = bv_count + 1;
    if (load_pulse === 1'b1) begin
      lp_count      = lp_count + 1;
      last_load_val = count_value;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transfer: ce0 low for 4 cycles with the byte presented, then high for 8.
  task automatic send_byte(input logic [7:0] b);
    ce0           = 1'b0;
    data_incoming = b;
    repeat (4) @(negedge clk);
    ce0  = 1'b1;
    sent = sent + 1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    bv_count      = 0;
    lp_count      = 0;
    sent          = 0;
    last_load_val = 8'h00;
    reset         = 1'b1;
    ce0           = 1'b1;
    data_incoming = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_count", count_value, 8'h00);
    check("rst_dout", data_outgoing, 8'h00);
    check("rst_err", err, 1'b0);
    check("rst_load", load_pulse, 1'b0);
    check("rst_bv", byte_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // ce0 held high through reset release: no spurious byte
    repeat (100) @(negedge clk);
    check("held_ce0_no_bv", bv_count, 0);

    // Byte timing with INC: byte_valid on the 3rd edge after ce0 sampled high
    ce0           = 1'b0;
    data_incoming = 8'h03;
    repeat (4) @(negedge clk);
    ce0  = 1'b1;
    sent = sent + 1;
    @(posedge clk); #1;
    check("lat_e1_bv", byte_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_e2_bv", byte_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_e3_bv", byte_valid, 1'b1);
    check("lat_e3_count", count_value, 8'h00);
    @(posedge clk); #1;
    check("lat_e4_bv", byte_valid, 1'b0);
    check("lat_e4_count", count_value, 8'h01);
    repeat (6) @(negedge clk);

    // Write then read
    send_byte(8'h01);
    check("wr_busy", busy, 1'b1);
    lp_before = lp_count;
    send_byte(8'hA5);
    check("wr_busy_after", busy, 1'b0);
    check("wr_count", count_value, 8'hA5);
    check("wr_load_once", lp_count - lp_before, 1);
    check("wr_load_val", last_load_val, 8'hA5);
    check("wr_dout_held", data_outgoing, 8'h00);
    send_byte(8'h02);
    check("rd_dout", data_outgoing, 8'hA5);

    // Wrap-around
    send_byte(8'h01);
    send_byte(8'hFF);
    check("wrap_load", count_value, 8'hFF);
    send_byte(8'h03);
    check("wrap_count", count_value, 8'h00);
    send_byte(8'h02);
    check("wrap_dout", data_outgoing, 8'h00);

    // Put a distinctive value on data_outgoing so holding is visible
    send_byte(8'h01);
    send_byte(8'h5A);
    send_byte(8'h02);
    check("rd2_dout", data_outgoing, 8'h5A);

    // Errors and CLEAR
    send_byte(8'h7E);
    check("err_set", err, 1'b1);
    check("err_idle", busy, 1'b0);
    check("err_count_held", count_value, 8'h5A);
    send_byte(8'h01);
    send_byte(8'h7E);
    check("err_operand_count", count_value, 8'h7E);
    check("err_sticky", err, 1'b1);
    send_byte(8'h04);
    check("clr_err", err, 1'b0);
    check("clr_count", count_value, 8'h00);
    check("clr_dout_held", data_outgoing, 8'h5A);

    // Reset mid-operation discards the pending operand
    send_byte(8'h01);
    check("mid_busy", busy, 1'b1);
    lp_before = lp_count;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_busy_rst", busy, 1'b0);
    check("mid_count_rst", count_value, 8'h00);
    send_byte(8'h03);
    check("mid_count", count_value, 8'h01);
    check("mid_no_load", lp_count - lp_before, 0);
    check("mid_busy_end", busy, 1'b0);

    // One byte_valid per transfer overall
    check("bv_total", bv_count, sent);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
